// File: rtl/alu_issue_if.sv
// Request/response channels between the datapath sequencer (master) and the ALU op issuer (slave).
interface alu_issue_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_aluop;
    logic [5:0]       req_funct;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output req_valid, req_aluop, req_funct, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_aluop, req_funct, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_op_issuer.sv
// Decodes aluop/funct into the ALU control code, drives the ALU for one cycle and returns its result.
// Optional macro ALU_ISSUER_ILLEGAL_TRAP_EN: illegal R-type funct skips the ALU and responds with rsp_err=1.
module alu_op_issuer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_if.slave       req_if,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zout
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] CTL_AND = 3'b000;
    localparam logic [2:0] CTL_OR  = 3'b001;
    localparam logic [2:0] CTL_ADD = 3'b010;
    localparam logic [2:0] CTL_XOR = 3'b011;
    localparam logic [2:0] CTL_NOR = 3'b100;
    localparam logic [2:0] CTL_SUB = 3'b110;
    localparam logic [2:0] CTL_SLT = 3'b111;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_ctl_q, alu_ctl_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [2:0]       dec_ctl;
`ifdef ALU_ISSUER_ILLEGAL_TRAP_EN
    logic             dec_illegal;
    logic             err_q, err_d;
`endif

    always_comb begin
        dec_ctl = CTL_ADD;
`ifdef ALU_ISSUER_ILLEGAL_TRAP_EN
        dec_illegal = 1'b0;
`endif
        case (req_if.req_aluop)
            2'b00: dec_ctl = CTL_ADD;
            2'b01: dec_ctl = CTL_SUB;
            2'b11: dec_ctl = CTL_OR;
            default: begin
                case (req_if.req_funct)
                    6'b100000: dec_ctl = CTL_ADD;
                    6'b100010: dec_ctl = CTL_SUB;
                    6'b100100: dec_ctl = CTL_AND;
                    6'b100101: dec_ctl = CTL_OR;
                    6'b100110: dec_ctl = CTL_XOR;
                    6'b100111: dec_ctl = CTL_NOR;
                    6'b101010: dec_ctl = CTL_SLT;
                    default: begin
                        // Unknown funct still drives a harmless add when not trapped.
                        dec_ctl = CTL_ADD;
`ifdef ALU_ISSUER_ILLEGAL_TRAP_EN
                        dec_illegal = 1'b1;
`endif
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_ctl_d = alu_ctl_q;
        result_d  = result_q;
        zero_d    = zero_q;
`ifdef ALU_ISSUER_ILLEGAL_TRAP_EN
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_if.req_valid) begin
`ifdef ALU_ISSUER_ILLEGAL_TRAP_EN
                    if (dec_illegal) begin
                        state_d  = RESP;
                        result_d = '0;
                        zero_d   = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        err_d    = 1'b0;
`else
                    begin
`endif
                        alu_a_d   = req_if.req_a;
                        alu_b_d   = req_if.req_b;
                        alu_ctl_d = dec_ctl;
                        state_d   = EXEC;
                    end
                end
            end
            EXEC: begin
                result_d = alu_out;
                zero_d   = alu_zout;
                state_d  = RESP;
            end
            RESP: begin
                if (req_if.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_ctl_q <= CTL_ADD;
            result_q  <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_ctl_q <= alu_ctl_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
        end
    end

`ifdef ALU_ISSUER_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign req_if.rsp_err = err_q;
`else
    assign req_if.rsp_err = 1'b0;
`endif

    assign req_if.req_ready  = (state_q == IDLE);
    assign req_if.rsp_valid  = (state_q == RESP);
    assign req_if.rsp_result = result_q;
    assign req_if.rsp_zero   = zero_q;
    assign alu_a             = alu_a_q;
    assign alu_b             = alu_b_q;
    assign alu_control       = alu_ctl_q;
endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a behavioural ALU attached to its ALU-side ports.
module tb_alu_op_issuer;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [2:0]       alu_control;
    logic             alu_zout;
    int               n_cmp = 0;
    int               n_mis = 0;

    alu_issue_if #(.WIDTH(WIDTH)) bus ();

    alu_op_issuer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_if      (bus.slave),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_out     (alu_out),
        .alu_zout    (alu_zout)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_out = '0;
        case (alu_control)
            3'b000: alu_out = alu_a & alu_b;
            3'b001: alu_out = alu_a | alu_b;
            3'b010: alu_out = alu_a + alu_b;
            3'b011: alu_out = alu_a ^ alu_b;
            3'b100: alu_out = ~(alu_a | alu_b);
            3'b110: alu_out = alu_a - alu_b;
            3'b111: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_out = '0;
        endcase
        alu_zout = (alu_out == '0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge; returns #1 after the accepting edge with req_valid dropped.
    task automatic start_req(input logic [1:0] op, input logic [5:0] fn,
                             input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.req_aluop = op;
        bus.req_funct = fn;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input int lat,
                         input logic [2:0] e_ctl, input logic [31:0] e_res,
                         input logic e_zero, input logic e_err);
        start_req(op, fn, a, b);
        if (lat == 2) begin
            chk({tag, "_exec_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
            chk({tag, "_exec_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
            chk({tag, "_ctl"}, {29'd0, alu_control}, {29'd0, e_ctl});
            @(posedge clk);
            #1;
        end else begin
            chk({tag, "_ctl_held"}, {29'd0, alu_control}, {29'd0, e_ctl});
        end
        chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        chk({tag, "_result"}, bus.rsp_result, e_res);
        chk({tag, "_zero"}, {31'd0, bus.rsp_zero}, {31'd0, e_zero});
        chk({tag, "_err"}, {31'd0, bus.rsp_err}, {31'd0, e_err});
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
        chk({tag, "_back_idle"}, {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_aluop = 2'b00;
        bus.req_funct = 6'd0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_ctl", {29'd0, alu_control}, 32'd2);
        chk("rst_result", bus.rsp_result, 32'd0);
        chk("rst_zero", {31'd0, bus.rsp_zero}, 32'd0);
        chk("rst_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        reset = 1'b0;

        do_op("radd", 2'b10, 6'b100000, 32'd5, 32'd7, 2, 3'b010, 32'd12, 1'b0, 1'b0);
        do_op("beq",  2'b01, 6'b101010, 32'd9, 32'd9, 2, 3'b110, 32'd0,  1'b1, 1'b0);
        do_op("slt",  2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 2, 3'b111, 32'd1, 1'b0, 1'b0);
        do_op("rnor", 2'b10, 6'b100111, 32'h0000_FFFF, 32'h00FF_0000, 2, 3'b100,
              32'hFF00_0000, 1'b0, 1'b0);
        do_op("lw",   2'b00, 6'b111111, 32'd3, 32'd4, 2, 3'b010, 32'd7, 1'b0, 1'b0);

        // Response back-pressure with a competing request waiting.
        start_req(2'b11, 6'd0, 32'h0000_00F0, 32'h0000_000F);
        chk("hold_ctl", {29'd0, alu_control}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_aluop = 2'b00;
        bus.req_a     = 32'd99;
        bus.req_b     = 32'd1;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("hold_result", bus.rsp_result, 32'h0000_00FF);
            chk("hold_alu_a", alu_a, 32'h0000_00F0);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        chk("hold_release", {31'd0, bus.rsp_valid}, 32'd0);
        chk("hold_no_reissue", alu_a, 32'h0000_00F0);

`ifdef ALU_ISSUER_ILLEGAL_TRAP_EN
        do_op("illegal", 2'b10, 6'b111111, 32'd3, 32'd4, 1, 3'b001, 32'd0, 1'b0, 1'b1);
        chk("illegal_alu_a", alu_a, 32'h0000_00F0);
        do_op("post_trap", 2'b10, 6'b100110, 32'hF0F0_F0F0, 32'hFF00_FF00, 2, 3'b011,
              32'h0FF0_0FF0, 1'b0, 1'b0);
`else
        do_op("illegal", 2'b10, 6'b111111, 32'd3, 32'd4, 2, 3'b010, 32'd7, 1'b0, 1'b0);
`endif

        // Reset while the op is in EXEC drops it.
        start_req(2'b10, 6'b100010, 32'd10, 32'd3);
        chk("rstx_ctl", {29'd0, alu_control}, 32'd6);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rstx_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rstx_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rstx_ctl_reset", {29'd0, alu_control}, 32'd2);
        chk("rstx_result", bus.rsp_result, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstx_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);

        do_op("rand", 2'b10, 6'b100100, 32'hF0F0_1234, 32'h0F0F_FFFF, 2, 3'b000,
              32'h0000_1234, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
